// File: rtl/hevc_subpel_row_engine.sv
// HEVC luma sub-pel row engine: streams reference rows through the 8-tap
// quarter/half/three-quarter filters with a 2-stage valid/ready pipeline.
module hevc_subpel_row_engine #(
    parameter int unsigned BLK_W    = 8,
    parameter int unsigned NUM_ROWS = 15,
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned OUT_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           mode,
    output logic [7:0]                     next_row,
    input  logic [(BLK_W+7)*PIX_W-1:0]     in_row,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [BLK_W*OUT_W-1:0]         out_a,
    output logic [BLK_W*OUT_W-1:0]         out_b,
    output logic [BLK_W*OUT_W-1:0]         out_c,
    output logic [7:0]                     out_row,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned IN_W = (BLK_W + 7) * PIX_W;
    localparam int unsigned OW   = BLK_W * OUT_W;
    localparam int unsigned SW   = PIX_W + 8;
    localparam int unsigned PMAX = (1 << PIX_W) - 1;

    // Tap k lives in bits [8k +: 8], applied to p[i+k].
    localparam logic [63:0] TAPS_A = {8'h00, 8'h01, 8'hFB, 8'h11, 8'h3A, 8'hF6, 8'h04, 8'hFF};
    localparam logic [63:0] TAPS_B = {8'hFF, 8'h04, 8'hF5, 8'h28, 8'h28, 8'hF5, 8'h04, 8'hFF};
    localparam logic [63:0] TAPS_C = {8'hFF, 8'h04, 8'hF6, 8'h3A, 8'h11, 8'hFB, 8'h01, 8'h00};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic              mode_q;
    logic [7:0]        in_cnt;
    logic [7:0]        out_cnt;
    logic              s1_valid;
    logic [IN_W-1:0]   s1_row;
    logic [7:0]        s1_idx;
    logic [OW-1:0]     f_a, f_b, f_c;
    logic              stall, accept, handshake;

    // Signed 8-tap dot product over one window of PIX_W-bit pixels.
    function automatic logic signed [SW-1:0] fir8(input logic [8*PIX_W-1:0] win,
                                                 input logic [63:0] taps);
        logic signed [SW-1:0] acc;
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            acc = acc + SW'($signed({1'b0, win[PIX_W*k +: PIX_W]}))
                      * SW'($signed(taps[8*k +: 8]));
        end
        return acc;
    endfunction

    // Final pel (round, shift, clip) or intermediate (scale, sign-extend).
    function automatic logic [OUT_W-1:0] post(input logic signed [SW-1:0] s,
                                             input logic inter);
        logic signed [SW-1:0] r;
        if (inter) begin
            r = s >>> (PIX_W - 8);
            return OUT_W'(r);
        end
        r = (s + SW'(32)) >>> 6;
        if (r[SW-1]) begin
            return '0;
        end
        if (r[SW-2:0] > (SW-1)'(PMAX)) begin
            return OUT_W'(PMAX);
        end
        return OUT_W'(r[PIX_W-1:0]);
    endfunction

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = (state == RUN) & (in_cnt < 8'(NUM_ROWS)) & ~stall;
    assign accept    = in_valid & in_ready;
    assign handshake = out_valid & out_ready;
    assign next_row  = in_cnt;
    assign busy      = (state != IDLE);

    // Filter bank for all BLK_W output positions of the staged row.
    always_comb begin
        f_a = '0;
        f_b = '0;
        f_c = '0;
        for (int i = 0; i < BLK_W; i++) begin
            f_a[OUT_W*i +: OUT_W] = post(fir8(s1_row[PIX_W*i +: 8*PIX_W], TAPS_A), mode_q);
            f_b[OUT_W*i +: OUT_W] = post(fir8(s1_row[PIX_W*i +: 8*PIX_W], TAPS_B), mode_q);
            f_c[OUT_W*i +: OUT_W] = post(fir8(s1_row[PIX_W*i +: 8*PIX_W], TAPS_C), mode_q);
        end
    end

    // Job control: state, row counters and the completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mode_q  <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start landing on the done cycle is ignored so the two never coincide.
                    if (start && !done) begin
                        state   <= RUN;
                        mode_q  <= mode;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        in_cnt <= in_cnt + 8'd1;
                        if (in_cnt == 8'(NUM_ROWS - 1)) begin
                            state <= DRAIN;
                        end
                    end
                    if (handshake) begin
                        out_cnt <= out_cnt + 8'd1;
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        out_cnt <= out_cnt + 8'd1;
                        if (out_cnt == 8'(NUM_ROWS - 1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage datapath; every stage holds while the output is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_row    <= '0;
            s1_idx    <= '0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            out_row   <= '0;
        end else if (!stall) begin
            s1_valid  <= accept;
            if (accept) begin
                s1_row <= in_row;
                s1_idx <= in_cnt;
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_a   <= f_a;
                out_b   <= f_b;
                out_c   <= f_c;
                out_row <= s1_idx;
            end
        end
    end

endmodule
